// File: rtl/nrisc_ula_wb.sv
// Writeback and flags stage behind the NRISC ALU: tags issued ops, retires flags, and queues results.
// Optional operand forwarding is enabled with the NRISC_WB_FWD_EN macro.
module nrisc_ula_wb #(
    parameter int TAM    = 32,
    parameter int REG_AW = 4,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              iss_valid,
    input  logic [REG_AW-1:0] iss_rd,
    input  logic              iss_wr,
    input  logic              iss_fl,
    output logic              iss_stall,
    input  logic [TAM-1:0]    ULA_OUT,
    input  logic [2:0]        ULA_flags,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [REG_AW-1:0] wb_addr,
    output logic [TAM-1:0]    wb_data,
    output logic [2:0]        flags_q,
    input  logic [REG_AW-1:0] hz_ra,
    input  logic [REG_AW-1:0] hz_rb,
    output logic              hz_a,
    output logic              hz_b
`ifdef NRISC_WB_FWD_EN
    ,
    output logic [TAM-1:0]    fwd_a_data,
    output logic [TAM-1:0]    fwd_b_data
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    // Tag stage: describes the op whose result is on ULA_OUT this cycle.
    logic              t_valid;
    logic [REG_AW-1:0] t_rd;
    logic              t_wr;
    logic              t_fl;

    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count;
    logic [REG_AW-1:0] mem_addr [DEPTH];
    logic [TAM-1:0]    mem_data [DEPTH];

    logic              push_pend;
    logic              pop;
    logic              full;
    logic              push;
    logic              accept;
    logic [CW:0]       occ_next;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid never waits on ready, and payload holds stable while valid is high and ready is low.
    assign push_pend = t_valid & t_wr;
    assign wb_valid  = (count != '0);
    assign pop       = wb_valid & wb_ready;
    assign full      = (count == CW'(DEPTH));
    assign push      = push_pend & (~full | pop);

    // Stall looks one op ahead: the op in the tag stage already owns a FIFO slot.
    // wb_ready reaches iss_stall combinationally through pop.
    assign occ_next  = {1'b0, count} + (CW+1)'(push_pend) - (CW+1)'(pop);
    assign iss_stall = (occ_next >= (CW+1)'(DEPTH));
    assign accept    = iss_valid & ~iss_stall;

    assign wb_addr   = wb_valid ? mem_addr[rd_ptr] : '0;
    assign wb_data   = wb_valid ? mem_data[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_valid <= 1'b0;
            t_rd    <= '0;
            t_wr    <= 1'b0;
            t_fl    <= 1'b0;
            flags_q <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
        end else begin
            t_valid <= accept;
            if (accept) begin
                t_rd <= iss_rd;
                t_wr <= iss_wr;
                t_fl <= iss_fl;
            end
            if (t_valid && t_fl) begin
                flags_q <= ULA_flags;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr] <= t_rd;
            mem_data[wr_ptr] <= ULA_OUT;
        end
    end

    overflow_push: assert property (@(posedge clk) disable iff (!rst_n) !(push_pend && full && !pop))
        else $error("nrisc_ula_wb: push into full result FIFO dropped");

`ifdef NRISC_WB_FWD_EN
    logic [TAM-1:0] fa;
    logic [TAM-1:0] fb;
    assign fwd_a_data = fa;
    assign fwd_b_data = fb;
`endif

    // Scan oldest to newest so later hits override; the tag stage is newest of all.
    always_comb begin
        hz_a = 1'b0;
        hz_b = 1'b0;
`ifdef NRISC_WB_FWD_EN
        fa = '0;
        fb = '0;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            if (CW'(k) < count) begin
                if (mem_addr[rd_ptr + PW'(k)] == hz_ra) begin
                    hz_a = 1'b1;
`ifdef NRISC_WB_FWD_EN
                    fa = mem_data[rd_ptr + PW'(k)];
`endif
                end
                if (mem_addr[rd_ptr + PW'(k)] == hz_rb) begin
                    hz_b = 1'b1;
`ifdef NRISC_WB_FWD_EN
                    fb = mem_data[rd_ptr + PW'(k)];
`endif
                end
            end
        end
        if (push_pend && (t_rd == hz_ra)) begin
            hz_a = 1'b1;
`ifdef NRISC_WB_FWD_EN
            fa = ULA_OUT;
`endif
        end
        if (push_pend && (t_rd == hz_rb)) begin
            hz_b = 1'b1;
`ifdef NRISC_WB_FWD_EN
            fb = ULA_OUT;
`endif
        end
    end

endmodule

// File: tb/tb_nrisc_ula_wb.sv
// Bench for nrisc_ula_wb: a registered-ALU model feeds ULA_OUT, a scoreboard checks every writeback.
module tb_nrisc_ula_wb;

    logic        clk;
    logic        rst_n;
    logic        iss_valid;
    logic [3:0]  iss_rd;
    logic        iss_wr;
    logic        iss_fl;
    logic        iss_stall;
    logic [31:0] ULA_OUT;
    logic [2:0]  ULA_flags;
    logic        wb_valid;
    logic        wb_ready;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic [2:0]  flags_q;
    logic [3:0]  hz_ra;
    logic [3:0]  hz_rb;
    logic        hz_a;
    logic        hz_b;
`ifdef NRISC_WB_FWD_EN
    logic [31:0] fwd_a_data;
    logic [31:0] fwd_b_data;
`endif

    int errors = 0;
    int checks = 0;
    int pops   = 0;

    logic [35:0] exp_q[$];
    logic [31:0] op_data;
    logic [2:0]  op_flags;
    logic        alu_acc;
    logic [31:0] alu_d;
    logic [2:0]  alu_f;

    nrisc_ula_wb #(.TAM(32), .REG_AW(4), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_wr(iss_wr), .iss_fl(iss_fl),
        .iss_stall(iss_stall),
        .ULA_OUT(ULA_OUT), .ULA_flags(ULA_flags),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
        .flags_q(flags_q),
        .hz_ra(hz_ra), .hz_rb(hz_rb), .hz_a(hz_a), .hz_b(hz_b)
`ifdef NRISC_WB_FWD_EN
        , .fwd_a_data(fwd_a_data), .fwd_b_data(fwd_b_data)
`endif
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: check writebacks about to transfer, then record newly accepted ops.
    task automatic monitor();
        logic [35:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && wb_valid && wb_ready) begin
                pops++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL wb_unexpected got addr=%0d data=%h required none", wb_addr, wb_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({wb_addr, wb_data} !== e) begin
                        errors++;
                        $display("FAIL wb_order got addr=%0d data=%h required addr=%0d data=%h",
                                 wb_addr, wb_data, e[35:32], e[31:0]);
                    end
                end
            end
            alu_acc = rst_n && iss_valid && !iss_stall;
            alu_d   = op_data;
            alu_f   = op_flags;
            if (alu_acc && iss_wr) exp_q.push_back({iss_rd, op_data});
        end
    endtask

    // Registered ALU model: result of an op accepted at an edge appears just after it.
    task automatic alu_model();
        forever begin
            @(posedge clk);
            #1;
            if (alu_acc) begin
                ULA_OUT   = alu_d;
                ULA_flags = alu_f;
            end else begin
                ULA_OUT   = 32'hDEAD_BEEF;
                ULA_flags = 3'b101;
            end
        end
    endtask

    // Driver: called just after a rising edge, returns just after the next one.
    task automatic drive_op(input logic [3:0] rd, input logic wr, input logic fl,
                            input logic [31:0] d, input logic [2:0] f);
        iss_valid = 1'b1; iss_rd = rd; iss_wr = wr; iss_fl = fl; op_data = d; op_flags = f;
        @(posedge clk); #1;
        iss_valid = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rst_wb_valid got=%b required=0", wb_valid); end
        checks++; if (iss_stall !== 1'b0) begin errors++; $display("FAIL rst_stall got=%b required=0", iss_stall); end
        checks++; if (flags_q !== 3'b000) begin errors++; $display("FAIL rst_flags got=%b required=000", flags_q); end
        checks++; if ({wb_addr, wb_data} !== 36'h0) begin errors++; $display("FAIL rst_wb_bus got=%h required=0", {wb_addr, wb_data}); end
        checks++; if ({hz_a, hz_b} !== 2'b00) begin errors++; $display("FAIL rst_hz got=%b required=00", {hz_a, hz_b}); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_flags_only();
        drive_op(4'd9, 1'b0, 1'b1, 32'h0000_1234, 3'b011);
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL fo_wb_valid1 got=%b required=0", wb_valid); end
        @(posedge clk); #1;
        checks++; if (flags_q !== 3'b011) begin errors++; $display("FAIL fo_flags got=%b required=011", flags_q); end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL fo_wb_valid2 got=%b required=0", wb_valid); end
        @(posedge clk); #1;
        checks++; if (flags_q !== 3'b011) begin errors++; $display("FAIL fo_flags_hold got=%b required=011", flags_q); end
    endtask

    task automatic test_single();
        drive_op(4'd5, 1'b1, 1'b1, 32'h0000_00A5, 3'b000);
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL so_no_bypass got=%b required=0", wb_valid); end
        @(posedge clk); #1;
        checks++; if (flags_q !== 3'b000) begin errors++; $display("FAIL so_flags got=%b required=000", flags_q); end
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL so_wb_valid got=%b required=1", wb_valid); end
        checks++; if (wb_addr !== 4'd5) begin errors++; $display("FAIL so_wb_addr got=%0d required=5", wb_addr); end
        checks++; if (wb_data !== 32'h0000_00A5) begin errors++; $display("FAIL so_wb_data got=%h required=000000a5", wb_data); end
        @(posedge clk); #1;
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL so_popped got=%b required=0", wb_valid); end
    endtask

    task automatic test_back_to_back();
        wb_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            if (i < 8) begin
                iss_valid = 1'b1; iss_rd = 4'(i + 1); iss_wr = 1'b1; iss_fl = 1'b0;
                op_data = $urandom; op_flags = 3'($urandom_range(0, 7));
            end else begin
                iss_valid = 1'b0;
            end
            @(negedge clk);
            if (i < 8) begin
                checks++; if (iss_stall !== 1'b0) begin errors++; $display("FAIL b2b_stall[%0d] got=%b required=0", i, iss_stall); end
            end
            checks++;
            if (wb_valid !== (i >= 2 && i <= 9)) begin
                errors++; $display("FAIL b2b_wb_valid[%0d] got=%b required=%b", i, wb_valid, (i >= 2 && i <= 9));
            end else if (wb_valid && wb_addr !== 4'(i - 1)) begin
                errors++; $display("FAIL b2b_wb_addr[%0d] got=%0d required=%0d", i, wb_addr, i - 1);
            end
            @(posedge clk); #1;
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_drain got=%0d required=0", exp_q.size()); end
    endtask

    task automatic test_backpressure();
        logic [31:0] d1;
        int          p0;
        d1 = $urandom;
        p0 = pops;
        wb_ready = 1'b0;
        iss_valid = 1'b1; iss_rd = 4'd1; iss_wr = 1'b1; iss_fl = 1'b0; op_data = d1; op_flags = 3'b000;
        @(negedge clk);
        checks++; if (iss_stall !== 1'b0) begin errors++; $display("FAIL bp_stall_r1 got=%b required=0", iss_stall); end
        @(posedge clk); #1;
        iss_rd = 4'd2; op_data = $urandom;
        @(negedge clk);
        checks++; if (iss_stall !== 1'b0) begin errors++; $display("FAIL bp_stall_r2 got=%b required=0", iss_stall); end
        @(posedge clk); #1;
        iss_rd = 4'd3; op_data = $urandom;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++; if (iss_stall !== 1'b1) begin errors++; $display("FAIL bp_stall_r3[%0d] got=%b required=1", c, iss_stall); end
            checks++; if (wb_valid !== 1'b1 || wb_addr !== 4'd1 || wb_data !== d1) begin
                errors++; $display("FAIL bp_hold[%0d] got=%b/%0d/%h required=1/1/%h", c, wb_valid, wb_addr, wb_data, d1);
            end
            @(posedge clk); #1;
        end
        wb_ready = 1'b1;
        @(negedge clk);
        checks++; if (iss_stall !== 1'b0) begin errors++; $display("FAIL bp_release got=%b required=0", iss_stall); end
        @(posedge clk); #1;
        iss_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        checks++; if (exp_q.size() != 0 || wb_valid !== 1'b0) begin
            errors++; $display("FAIL bp_drain got=%0d/%b required=0/0", exp_q.size(), wb_valid);
        end
        checks++; if (pops - p0 != 3) begin errors++; $display("FAIL bp_pop_count got=%0d required=3", pops - p0); end
    endtask

    task automatic test_hazard();
        wb_ready = 1'b0;
        drive_op(4'd7, 1'b1, 1'b0, 32'h0000_0011, 3'b000);
        drive_op(4'd7, 1'b1, 1'b0, 32'h0000_0022, 3'b000);
        hz_ra = 4'd7; hz_rb = 4'd3;
        @(negedge clk);
        checks++; if (hz_a !== 1'b1) begin errors++; $display("FAIL hz_a_tag got=%b required=1", hz_a); end
        checks++; if (hz_b !== 1'b0) begin errors++; $display("FAIL hz_b_miss got=%b required=0", hz_b); end
`ifdef NRISC_WB_FWD_EN
        checks++; if (fwd_a_data !== 32'h22) begin errors++; $display("FAIL fwd_a_tag got=%h required=00000022", fwd_a_data); end
        checks++; if (fwd_b_data !== 32'h0) begin errors++; $display("FAIL fwd_b_miss got=%h required=0", fwd_b_data); end
`endif
        @(posedge clk); #1;
        hz_ra = 4'd3; hz_rb = 4'd7;
        @(negedge clk);
        checks++; if ({hz_a, hz_b} !== 2'b01) begin errors++; $display("FAIL hz_fifo got=%b required=01", {hz_a, hz_b}); end
`ifdef NRISC_WB_FWD_EN
        checks++; if (fwd_b_data !== 32'h22) begin errors++; $display("FAIL fwd_b_newest got=%h required=00000022", fwd_b_data); end
`endif
        @(posedge clk); #1;
        wb_ready = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        checks++; if (hz_b !== 1'b0 || wb_valid !== 1'b0) begin
            errors++; $display("FAIL hz_clear got=%b/%b required=0/0", hz_b, wb_valid);
        end
        @(posedge clk); #1;
        hz_ra = 4'd0; hz_rb = 4'd0;
    endtask

    task automatic test_reset_mid();
        wb_ready = 1'b0;
        drive_op(4'd1, 1'b1, 1'b0, 32'hCAFE_0001, 3'b000);
        drive_op(4'd2, 1'b1, 1'b1, 32'hCAFE_0002, 3'b110);
        @(posedge clk); #1;
        checks++; if (wb_valid !== 1'b1 || iss_stall !== 1'b1 || flags_q !== 3'b110) begin
            errors++; $display("FAIL rm_setup got=%b/%b/%b required=1/1/110", wb_valid, iss_stall, flags_q);
        end
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rm_wb_valid got=%b required=0", wb_valid); end
        checks++; if (flags_q !== 3'b000) begin errors++; $display("FAIL rm_flags got=%b required=000", flags_q); end
        checks++; if (iss_stall !== 1'b0) begin errors++; $display("FAIL rm_stall got=%b required=0", iss_stall); end
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        wb_ready = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rm_no_wb got=%b required=0", wb_valid); end
        end
    endtask

    initial begin
        rst_n = 1'b0; iss_valid = 1'b0; iss_rd = '0; iss_wr = 1'b0; iss_fl = 1'b0;
        wb_ready = 1'b1; hz_ra = '0; hz_rb = '0; op_data = '0; op_flags = '0;
        ULA_OUT = 32'hDEAD_BEEF; ULA_flags = 3'b101; alu_acc = 1'b0; alu_d = '0; alu_f = '0;
        fork
            monitor();
            alu_model();
        join_none
        repeat (2) @(posedge clk);
        test_reset();
        test_flags_only();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_hazard();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nrisc_ula_wb.md
Name: nrisc_ula_wb

Overview:
- Writeback and flags stage directly downstream of the NRISC ALU (ULA).
- Tags each issued ALU operation with its destination register and write/flag enables, and aligns the tag with the ALU's registered result one cycle later.
- Latches the architectural flags register and buffers results in a small FIFO toward the shared register-file write port (valid/ready).
- Drives issue stall and read-after-write hazard signals back to the decode/issue stage.

Parameters:
TAM, 32, data width; must equal the ALU data width
REG_AW, 4, register address width (16 registers)
DEPTH, 2, result FIFO entries; power of two, >=2

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
iss_valid  in  1  ALU operation issued this cycle (operands at ALU inputs now)
iss_rd  in  REG_AW  destination register
iss_wr  in  1  result is written to iss_rd
iss_fl  in  1  operation updates flags
iss_stall  out  1  issue not accepted; upstream holds operation
ULA_OUT  in  TAM  registered ALU result
ULA_flags  in  3  registered ALU flags {minus, zero, carry}
wb_valid  out  1  writeback request to register file
wb_ready  in  1  register file accepts writeback
wb_addr  out  REG_AW  writeback register
wb_data  out  TAM  writeback data
flags_q  out  3  architectural flags {minus, zero, carry}
hz_ra  in  REG_AW  decode source register A
hz_rb  in  REG_AW  decode source register B
hz_a  out  1  RAW hazard on hz_ra
hz_b  out  1  RAW hazard on hz_rb

Behaviour:
Reset:
- rst_n low clears, asynchronously: tag stage (t_valid, t_rd, t_wr, t_fl), FIFO count and pointers, flags_q.
- All outputs read 0 during reset.
- Reset mid-operation discards the in-flight tag and all FIFO entries; nothing is written back.

Issue:
- An operation is accepted at the edge ending cycle N when iss_valid=1 and iss_stall=0.
- At that edge the tag captures {1, iss_rd, iss_wr, iss_fl}; otherwise t_valid <= 0.
- The ALU result for that operation is on ULA_OUT/ULA_flags during cycle N+1.

Retire (edge ending N+1):
- If t_valid & t_fl: flags_q <= ULA_flags, independent of FIFO state.
- If t_valid & t_wr: push {t_rd, ULA_OUT} into the FIFO.
- Operations with t_wr=0 and t_fl=0 retire silently.

Stall:
- push_pend = t_valid & t_wr; pop = wb_valid & wb_ready.
- iss_stall = (count - pop + push_pend) >= DEPTH.
- This is a combinational path from wb_ready to iss_stall (documented, intentional).
- Throughput is one operation per cycle when wb_ready stays high.

FIFO:
- wb_valid = (count != 0). wb_addr/wb_data show the oldest entry and hold stable while wb_valid & ~wb_ready.
- No bypass: an entry pushed at edge N+1 is visible from cycle N+2, the minimum issue-to-writeback latency.
- Simultaneous push and pop: count unchanged; works at count 0 through DEPTH-1 and at full when a pop occurs.
- Pointers wrap modulo DEPTH.
- Push while full with no pop (a protocol violation; the stall logic prevents it): the push is dropped, count unchanged, a simulation-only error message is printed.

Hazard:
- hz_a = 1 if hz_ra equals t_rd with t_valid & t_wr, or equals the address of any valid FIFO entry; hz_b likewise for hz_rb.
- Purely combinational. Register 0 is not exempt.

Optional Feature:
Macro NRISC_WB_FWD_EN.
- Defined: adds ports fwd_a_data and fwd_b_data (out, TAM). On a hazard hit each returns the newest matching value, priority: tag stage (ULA_OUT when t_valid & t_wr) first, then newest FIFO entry, then older entries. Value is 0 when there is no hit. hz_a/hz_b then mean "forwardable". Decode uses the forwarded value and does not stall.
- Undefined: no forwarding ports or logic. hz_a/hz_b are hazard-only; decode must stall until the hazard clears.

Test Plan:
- Reset: rst_n=0 mid-stream with count=2 -> wb_valid=0, flags_q=0, iss_stall=0 immediately; after release no writeback of the pre-reset data appears.
- Single op: issue at N with iss_rd=5, iss_wr=1, iss_fl=1; ULA_OUT=0x0000_00A5, ULA_flags=3'b000 at N+1 -> flags_q=000 after N+1; wb_valid=1, wb_addr=5, wb_data=0xA5 in N+2; pop with wb_ready=1.
- Back-to-back, wb_ready=1: issue 8 ops to r1..r8 on consecutive cycles -> iss_stall never asserts; writebacks r1..r8 in order on consecutive cycles starting N+2.
- Backpressure: wb_ready=0, issue r1, r2, r3 -> r3 stalls once count=2 and r2 is pending; wb_data held stable; raise wb_ready -> r1, r2, r3 drain in order, no loss, no duplicates.
- Flags-only: iss_wr=0, iss_fl=1, ULA_flags=3'b011 -> flags_q=011, no push, wb_valid stays 0.
- Hazard/forward: r7 in FIFO holding 0x11, new op to r7 in tag stage with ULA_OUT=0x22, hz_ra=7 -> hz_a=1; with NRISC_WB_FWD_EN, fwd_a_data=0x22; with hz_rb=3, hz_b=0.
